// File: rtl/serdes_tx_pkg.sv
// Package: serdes_tx_pkg
// Purpose: Shared definitions for the SERDES transmit framer.
//   COMMA_BYTE   - K28.1 comma character placed in every byte of a comma word
//   tx_state_t   - framer FSM states (periodic comma burst / data window)
//   comma_word() - builds a comma word of nb bytes, right-aligned in a wide
//                  vector that callers truncate to their own word width
package serdes_tx_pkg;

    localparam logic [7:0] COMMA_BYTE   = 8'h3C;
    localparam int         COMMA_MAX_NB = 32;

    typedef enum logic {
        ST_BURST,
        ST_DATA
    } tx_state_t;

    // Fills the low nb bytes with the comma character and leaves the rest zero.
    function automatic logic [8*COMMA_MAX_NB-1:0] comma_word(input int nb);
        logic [8*COMMA_MAX_NB-1:0] w;
        w = '0;
        for (int i = 0; i < COMMA_MAX_NB; i++) begin
            if (i < nb) begin
                w[8*i +: 8] = COMMA_BYTE;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/serdes_tx_fifo.sv
// Module: serdes_tx_fifo
// Purpose: Small synchronous FIFO buffering framer input words.
//   No empty bypass: a word written into an empty FIFO is readable on the
//   following cycle. Writes while full and reads while empty are ignored.
// Ports:
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous active-low reset (discards contents)
//   enq    in   1      write wdata
//   wdata  in   WIDTH  word to store
//   deq    in   1      pop the head word
//   rdata  out  WIDTH  head word (valid while empty is 0)
//   full   out  1      DEPTH words stored
//   empty  out  1      no words stored
module serdes_tx_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enq,
    input  logic [WIDTH-1:0] wdata,
    input  logic             deq,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic [CNT_W:0]   count;
    logic             do_enq;
    logic             do_deq;

    assign full   = (count == (CNT_W+1)'(DEPTH));
    assign empty  = (count == '0);
    assign do_enq = enq && !full;
    assign do_deq = deq && !empty;
    assign rdata  = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_enq, do_deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/serdes_tx_framer.sv
// Module: serdes_tx_framer
// Purpose: SERDES transmit framer. Buffers K-flagged words from the DSP side,
//   drives the registered SERDES parallel port and fills idle cycles with
//   comma (K28.1) words. A periodic comma burst of COMMA_LEN words follows every
//   DATA_LEN-cycle data window, deferred until the current packet has ended.
// Ports:
//   dsp_clk        in   1       clock
//   dsp_rst_n      in   1       asynchronous active-low reset
//   tx_dat_i       in   DATA_W  word to transmit
//   tx_k_i         in   NB      per-byte K flags
//   tx_last_i      in   1       last word of a packet
//   tx_en          in   1       enqueue (only while tx_rdy)
//   tx_rdy         out  1       input buffer not full
//   ser_tx_clk     out  1       copy of dsp_clk
//   ser_t          out  DATA_W  registered SERDES data
//   ser_tk         out  NB      registered SERDES K flags
//   comma_burst_o  out  1       periodic burst on the wire
// Optional (macro SERDES_TX_STATS_EN):
//   stat_clr       in   1       synchronous clear of both counters
//   stat_data_cnt  out  32      saturating count of data words sent
//   stat_comma_cnt out  32      saturating count of burst and idle commas sent
module serdes_tx_framer
    import serdes_tx_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 2,
    parameter int COMMA_LEN  = 16,
    parameter int DATA_LEN   = 65536
) (
    input  logic                dsp_clk,
    input  logic                dsp_rst_n,
`ifdef SERDES_TX_STATS_EN
    input  logic                stat_clr,
    output logic [31:0]         stat_data_cnt,
    output logic [31:0]         stat_comma_cnt,
`endif
    input  logic [DATA_W-1:0]   tx_dat_i,
    input  logic [DATA_W/8-1:0] tx_k_i,
    input  logic                tx_last_i,
    input  logic                tx_en,
    output logic                tx_rdy,
    output logic                ser_tx_clk,
    output logic [DATA_W-1:0]   ser_t,
    output logic [DATA_W/8-1:0] ser_tk,
    output logic                comma_burst_o
);

    localparam int NB    = DATA_W / 8;
    localparam int FW    = DATA_W + NB + 1;
    localparam int WIN_W = $clog2((COMMA_LEN > DATA_LEN) ? COMMA_LEN : DATA_LEN);

    localparam logic [DATA_W-1:0] COMMA_WORD = DATA_W'(comma_word(NB));
    localparam logic [WIN_W-1:0]  COMMA_LOAD = WIN_W'(COMMA_LEN - 1);
    localparam logic [WIN_W-1:0]  DATA_LOAD  = WIN_W'(DATA_LEN - 1);

    tx_state_t         state, state_nxt;
    logic [WIN_W-1:0]  win_cnt, win_cnt_nxt;
    logic              burst_pend, burst_pend_nxt;
    logic              in_pkt, in_pkt_nxt;
    logic              pend_now;
    logic              deq;
    logic [DATA_W-1:0] ser_t_nxt;
    logic [NB-1:0]     ser_tk_nxt;
    logic              burst_nxt;

    logic [FW-1:0]     fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dat;
    logic [NB-1:0]     fifo_k;
    logic              fifo_last;

    assign ser_tx_clk = dsp_clk;
    assign tx_rdy     = !fifo_full;
    assign fifo_dat   = fifo_rdata[DATA_W-1:0];
    assign fifo_k     = fifo_rdata[DATA_W +: NB];
    assign fifo_last  = fifo_rdata[FW-1];

    serdes_tx_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (dsp_clk),
        .rst_n (dsp_rst_n),
        .enq   (tx_en),
        .wdata ({tx_last_i, tx_k_i, tx_dat_i}),
        .deq   (deq),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State, window counter, packet tracking and the registered SERDES port.
    always_ff @(posedge dsp_clk or negedge dsp_rst_n) begin
        if (!dsp_rst_n) begin
            state         <= ST_BURST;
            win_cnt       <= COMMA_LOAD;
            burst_pend    <= 1'b0;
            in_pkt        <= 1'b0;
            ser_t         <= COMMA_WORD;
            ser_tk        <= '1;
            comma_burst_o <= 1'b1;
        end else begin
            state         <= state_nxt;
            win_cnt       <= win_cnt_nxt;
            burst_pend    <= burst_pend_nxt;
            in_pkt        <= in_pkt_nxt;
            ser_t         <= ser_t_nxt;
            ser_tk        <= ser_tk_nxt;
            comma_burst_o <= burst_nxt;
        end
    end

    // A burst becomes due when the window counter is at 0 (or already was).
    // It starts only when this cycle leaves no packet open, so a packet whose
    // last word goes out on the expiry cycle is followed straight by the burst.
    always_comb begin
        state_nxt      = state;
        win_cnt_nxt    = win_cnt;
        burst_pend_nxt = burst_pend;
        in_pkt_nxt     = in_pkt;
        pend_now       = 1'b0;
        deq            = 1'b0;
        ser_t_nxt      = COMMA_WORD;
        ser_tk_nxt     = '1;
        burst_nxt      = 1'b0;
        case (state)
            ST_BURST: begin
                burst_nxt = 1'b1;
                if (win_cnt == '0) begin
                    win_cnt_nxt = DATA_LOAD;
                    state_nxt   = ST_DATA;
                end else begin
                    win_cnt_nxt = win_cnt - 1'b1;
                end
            end
            ST_DATA: begin
                if (!fifo_empty) begin
                    deq        = 1'b1;
                    ser_t_nxt  = fifo_dat;
                    ser_tk_nxt = fifo_k;
                    in_pkt_nxt = !fifo_last;
                end
                pend_now = burst_pend || (win_cnt == '0);
                if (win_cnt != '0) begin
                    win_cnt_nxt = win_cnt - 1'b1;
                end
                if (pend_now && !in_pkt_nxt) begin
                    state_nxt      = ST_BURST;
                    win_cnt_nxt    = COMMA_LOAD;
                    burst_pend_nxt = 1'b0;
                end else if (pend_now) begin
                    burst_pend_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_BURST;
            end
        endcase
    end

`ifdef SERDES_TX_STATS_EN
    // Saturating word counters; a clear wins over a same-cycle increment.
    always_ff @(posedge dsp_clk or negedge dsp_rst_n) begin
        if (!dsp_rst_n) begin
            stat_data_cnt  <= '0;
            stat_comma_cnt <= '0;
        end else if (stat_clr) begin
            stat_data_cnt  <= '0;
            stat_comma_cnt <= '0;
        end else if (deq) begin
            if (stat_data_cnt != 32'hFFFF_FFFF) begin
                stat_data_cnt <= stat_data_cnt + 1'b1;
            end
        end else begin
            if (stat_comma_cnt != 32'hFFFF_FFFF) begin
                stat_comma_cnt <= stat_comma_cnt + 1'b1;
            end
        end
    end
`endif

    // Cycles a due burst has been held off by an unfinished packet.
    logic [31:0] defer_cnt;

    always_ff @(posedge dsp_clk or negedge dsp_rst_n) begin
        if (!dsp_rst_n) begin
            defer_cnt <= '0;
        end else if (state == ST_DATA && burst_pend) begin
            if (defer_cnt != 32'hFFFF_FFFF) begin
                defer_cnt <= defer_cnt + 1'b1;
            end
        end else begin
            defer_cnt <= '0;
        end
    end

    // Enqueue while full drops the word; the source must respect tx_rdy.
    always @(posedge dsp_clk) begin
        if (dsp_rst_n && tx_en) begin
            assert (tx_rdy)
                else $warning("serdes_tx_framer: tx_en while tx_rdy low, word dropped");
        end
    end

    // A packet that never ends keeps the alignment burst off the link.
    always @(posedge dsp_clk) begin
        if (dsp_rst_n) begin
            assert (defer_cnt <= 32'(DATA_LEN))
                else $error("serdes_tx_framer: comma burst deferred longer than DATA_LEN cycles");
        end
    end

endmodule

// File: tb/tb_serdes_tx_framer.sv
// Testbench: tb_serdes_tx_framer
// Purpose: directed self-checking bench for serdes_tx_framer built with
//   COMMA_LEN=4, DATA_LEN=8, FIFO_DEPTH=4, DATA_W=16. Covers reset state,
//   the burst/data cadence, burst deferral past a straddling packet, FIFO
//   overflow while the sink is in a burst, idle commas mid-packet, and
//   (with SERDES_TX_STATS_EN) the statistics counters.
`timescale 1ns/1ps
module tb_serdes_tx_framer;

    localparam int DATA_W     = 16;
    localparam int NB         = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 2;
    localparam int COMMA_LEN  = 4;
    localparam int DATA_LEN   = 8;
    localparam logic [15:0] COMMA = 16'h3C3C;

    logic              dsp_clk   = 1'b0;
    logic              dsp_rst_n = 1'b0;
    logic [DATA_W-1:0] tx_dat_i  = '0;
    logic [NB-1:0]     tx_k_i    = '0;
    logic              tx_last_i = 1'b0;
    logic              tx_en     = 1'b0;
    logic              tx_rdy;
    logic              ser_tx_clk;
    logic [DATA_W-1:0] ser_t;
    logic [NB-1:0]     ser_tk;
    logic              comma_burst_o;
`ifdef SERDES_TX_STATS_EN
    logic              stat_clr = 1'b0;
    logic [31:0]       stat_data_cnt;
    logic [31:0]       stat_comma_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int pushed       = 0;

    always #5 dsp_clk = ~dsp_clk;

    serdes_tx_framer #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W),
        .COMMA_LEN  (COMMA_LEN),
        .DATA_LEN   (DATA_LEN)
    ) dut (
        .dsp_clk        (dsp_clk),
        .dsp_rst_n      (dsp_rst_n),
`ifdef SERDES_TX_STATS_EN
        .stat_clr       (stat_clr),
        .stat_data_cnt  (stat_data_cnt),
        .stat_comma_cnt (stat_comma_cnt),
`endif
        .tx_dat_i       (tx_dat_i),
        .tx_k_i         (tx_k_i),
        .tx_last_i      (tx_last_i),
        .tx_en          (tx_en),
        .tx_rdy         (tx_rdy),
        .ser_tx_clk     (ser_tx_clk),
        .ser_t          (ser_t),
        .ser_tk         (ser_tk),
        .comma_burst_o  (comma_burst_o)
    );

    function automatic logic [15:0] word_dat(input int n);
        return 16'hA000 | 16'(n);
    endfunction

    function automatic logic [1:0] word_k(input int n);
        return 2'(n);
    endfunction

    task automatic applyStimulus(input logic en, input logic [15:0] dat,
                                 input logic [1:0] k, input logic last);
        tx_en     = en;
        tx_dat_i  = dat;
        tx_k_i    = k;
        tx_last_i = last;
    endtask

    // Outputs are sampled 1 ns after the rising edge, inputs change there too.
    task automatic tick();
        @(posedge dsp_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkWord(input string tag, input logic [15:0] dat,
                             input logic [1:0] k, input logic burst);
        checkOutput({tag, " ser_t"},  32'(ser_t),         32'(dat));
        checkOutput({tag, " ser_tk"}, 32'(ser_tk),        32'(k));
        checkOutput({tag, " burst"},  32'(comma_burst_o), 32'(burst));
    endtask

    task automatic resetDut();
        applyStimulus(1'b0, '0, '0, 1'b0);
        dsp_rst_n = 1'b0;
        tick();
        tick();
        dsp_rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        applyStimulus(1'b0, '0, '0, 1'b0);
        tick();
        tick();
        checkWord("t1 reset", COMMA, 2'b11, 1'b1);
        checkOutput("t1 reset tx_rdy", 32'(tx_rdy), 32'd1);
        checkOutput("t1 ser_tx_clk", 32'(ser_tx_clk), 32'(dsp_clk));
        dsp_rst_n = 1'b1;

        // Continuous single-word packets: 4 burst commas then 8 data words, twice
        pushed = 0;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            if (tx_rdy) begin
                pushed++;
                applyStimulus(1'b1, word_dat(pushed), word_k(pushed), 1'b1);
            end else begin
                applyStimulus(1'b0, '0, '0, 1'b0);
            end
            tick();
            if (cyc <= 4 || (cyc >= 13 && cyc <= 16)) begin
                checkWord($sformatf("t2 c%0d burst", cyc), COMMA, 2'b11, 1'b1);
            end else if (cyc <= 12) begin
                checkWord($sformatf("t2 c%0d data", cyc), word_dat(cyc - 4), word_k(cyc - 4), 1'b0);
            end else begin
                checkWord($sformatf("t2 c%0d data", cyc), word_dat(cyc - 8), word_k(cyc - 8), 1'b0);
            end
            if (cyc == 4) begin
                checkOutput("t2 full after 4 words", 32'(tx_rdy), 32'd0);
            end
        end

        // Asynchronous reset mid-operation, checked before the next clock edge
        applyStimulus(1'b0, '0, '0, 1'b0);
        dsp_rst_n = 1'b0;
        #2;
        checkWord("t2 async reset", COMMA, 2'b11, 1'b1);
        checkOutput("t2 async reset tx_rdy", 32'(tx_rdy), 32'd1);

        // 5-word packet straddling window expiry; burst follows its last word
        resetDut();
        for (int cyc = 1; cyc <= 19; cyc++) begin
            if (cyc >= 9 && cyc <= 13) begin
                applyStimulus(1'b1, word_dat(100 + cyc), word_k(cyc), cyc == 13);
            end else begin
                applyStimulus(1'b0, '0, '0, 1'b0);
            end
            tick();
            if (cyc <= 4 || (cyc >= 15 && cyc <= 18)) begin
                checkWord($sformatf("t3 c%0d burst", cyc), COMMA, 2'b11, 1'b1);
            end else if (cyc >= 10 && cyc <= 14) begin
                checkWord($sformatf("t3 c%0d pkt", cyc), word_dat(100 + cyc - 1), word_k(cyc - 1), 1'b0);
            end else begin
                checkWord($sformatf("t3 c%0d idle", cyc), COMMA, 2'b11, 1'b0);
            end
        end

        // Six enqueue pulses while the sink sits in a burst: 4 kept, 2 dropped
        resetDut();
        for (int cyc = 1; cyc <= 21; cyc++) begin
            if (cyc >= 12 && cyc <= 17) begin
                applyStimulus(1'b1, word_dat(200 + cyc), word_k(cyc), 1'b1);
            end else begin
                applyStimulus(1'b0, '0, '0, 1'b0);
            end
            tick();
            if (cyc <= 4 || (cyc >= 13 && cyc <= 16)) begin
                checkWord($sformatf("t4 c%0d burst", cyc), COMMA, 2'b11, 1'b1);
            end else if (cyc >= 17 && cyc <= 20) begin
                checkWord($sformatf("t4 c%0d data", cyc), word_dat(200 + cyc - 5), word_k(cyc - 5), 1'b0);
            end else begin
                checkWord($sformatf("t4 c%0d idle", cyc), COMMA, 2'b11, 1'b0);
            end
            if (cyc == 14 || cyc == 17) begin
                checkOutput($sformatf("t4 c%0d tx_rdy", cyc), 32'(tx_rdy), 32'd1);
            end
            if (cyc == 15 || cyc == 16) begin
                checkOutput($sformatf("t4 c%0d tx_rdy", cyc), 32'(tx_rdy), 32'd0);
            end
        end

        // FIFO runs dry mid-packet for 3 cycles; the packet resumes intact
        resetDut();
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (cyc == 4 || cyc == 5 || cyc == 9 || cyc == 10) begin
                applyStimulus(1'b1, word_dat(300 + cyc), word_k(cyc), cyc == 10);
            end else begin
                applyStimulus(1'b0, '0, '0, 1'b0);
            end
            tick();
            if (cyc <= 4) begin
                checkWord($sformatf("t5 c%0d burst", cyc), COMMA, 2'b11, 1'b1);
            end else if (cyc == 5 || cyc == 6 || cyc == 10 || cyc == 11) begin
                checkWord($sformatf("t5 c%0d data", cyc), word_dat(300 + cyc - 1), word_k(cyc - 1), 1'b0);
            end else begin
                checkWord($sformatf("t5 c%0d idle", cyc), COMMA, 2'b11, 1'b0);
            end
        end

`ifdef SERDES_TX_STATS_EN
        // 10 data words and 8 commas, then a clear alongside a data word
        resetDut();
        pushed = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (tx_rdy && pushed < 11) begin
                pushed++;
                applyStimulus(1'b1, word_dat(400 + pushed), word_k(pushed), 1'b1);
            end else begin
                applyStimulus(1'b0, '0, '0, 1'b0);
            end
            stat_clr = (cyc == 19);
            tick();
            if (cyc == 18) begin
                checkOutput("t6 data count", stat_data_cnt, 32'd10);
                checkOutput("t6 comma count", stat_comma_cnt, 32'd8);
            end
            if (cyc == 19) begin
                checkOutput("t6 data count cleared", stat_data_cnt, 32'd0);
                checkOutput("t6 comma count cleared", stat_comma_cnt, 32'd0);
                checkWord("t6 send during clear", word_dat(411), word_k(11), 1'b0);
            end
            if (cyc == 20) begin
                checkOutput("t6 data count after", stat_data_cnt, 32'd0);
                checkOutput("t6 comma count after", stat_comma_cnt, 32'd1);
            end
        end
        stat_clr = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
